mips_ctrl_sequencer: RTL

- Registered successor to the multicycle MIPS next-state decoder.
- Holds the control-unit state register and computes transitions from the registered opcode and the memory-operation-complete (MOC) handshake.
- Adds a parametrised MOC watchdog, illegal-opcode and bus-error trap states, a fetch stall, and opcode latching at decode.
- Sits between the instruction register and the control-signal encoder; its state output drives the encoder.

---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/mips_moc_watchdog.sv | 35 +++
 rtl/mips_ctrl_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: state numbers,
// opcode constants and the wait-state classifier.
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_FETCH0     = 5'd0,
        ST_FETCH1     = 5'd1,
        ST_FETCH2     = 5'd2,
        ST_FETCH_WAIT = 5'd3,
        ST_DECODE     = 5'd4,
        ST_RTYPE      = 5'd5,
        ST_ADDI       = 5'd6,
        ST_SLTI       = 5'd7,
        ST_ANDI       = 5'd8,
        ST_ORI        = 5'd9,
        ST_XORI       = 5'd10,
        ST_LUI        = 5'd11,
        ST_BRANCH     = 5'd12,
        ST_JUMP       = 5'd13,
        ST_LOAD_ADDR  = 5'd14,
        ST_LW_RD      = 5'd15,
        ST_LW_WAIT    = 5'd16,
        ST_LOAD_WB    = 5'd17,
        ST_STORE_ADDR = 5'd18,
        ST_SW_WR      = 5'd19,
        ST_SW_WAIT    = 5'd20,
        ST_STORE_DONE = 5'd21,
        ST_BR_DONE    = 5'd22,
        ST_LB_RD      = 5'd23,
        ST_LB_WAIT    = 5'd24,
        ST_SB_WR      = 5'd25,
        ST_SB_WAIT    = 5'd26,
        ST_TRAP_ILL   = 5'd27,
        ST_TRAP_BUS   = 5'd28
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SD    = 6'b111111;

    function automatic logic is_wait_state(input logic [4:0] s);
        return (s == ST_FETCH_WAIT) || (s == ST_LW_WAIT) || (s == ST_SW_WAIT) ||
               (s == ST_LB_WAIT)    || (s == ST_SB_WAIT);
    endfunction

endpackage

// File: rtl/mips_moc_watchdog.sv
// Counts consecutive wait-state cycles with moc low and flags expiry on the
// cycle that would exceed MOC_TIMEOUT; MOC_TIMEOUT of 0 never expires.
module mips_moc_watchdog #(
    parameter int MOC_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_wait,
    input  logic moc,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MOC_TIMEOUT == 0) ? 0 : MOC_TIMEOUT - 1);

    logic [CNT_W-1:0] wdog;
    logic             stalled;

    always_comb begin
        stalled = in_wait && !moc;
        expired = (MOC_TIMEOUT != 0) && stalled && (wdog == LIMIT);
    end

    // An expiry or a moc=1 cycle always leaves the wait state, so both clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (stalled && !expired) begin
            wdog <= wdog + CNT_W'(1);
        end else begin
            wdog <= '0;
        end
    end

endmodule

// File: rtl/mips_ctrl_sequencer.sv
// Registered multicycle MIPS control sequencer: state register, opcode latch
// and next-state decode with MOC watchdog and trap states.
module mips_ctrl_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W     = 5,
    parameter int MOC_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               moc,
    input  logic               stall,
    input  logic               trap_ack,
    output logic [STATE_W-1:0] state,
    output logic               mem_wait,
    output logic               trap_illegal,
    output logic               trap_buserr
);

    logic [STATE_W-1:0] state_q;
    logic [5:0]         opcode_q;
    state_e             cur_st;
    state_e             state_nxt;
    logic               legal;
    logic               in_wait;
    logic               expired;

    // Encodings above 28, including any upper bits when STATE_W > 5, are illegal.
    always_comb begin
        legal   = ((state_q >> 5) == '0) && (state_q[4:0] <= 5'd28);
        cur_st  = state_e'(state_q[4:0]);
        in_wait = legal && is_wait_state(state_q[4:0]);
    end

    mips_moc_watchdog #(
        .MOC_TIMEOUT (MOC_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_wait (in_wait),
        .moc     (moc),
        .expired (expired)
    );

    always_comb begin
        state_nxt = ST_FETCH0;
        if (legal) begin
            case (cur_st)
                ST_FETCH0:     state_nxt = ST_FETCH1;
                ST_FETCH1:     state_nxt = stall ? ST_FETCH1 : ST_FETCH2;
                ST_FETCH2:     state_nxt = ST_FETCH_WAIT;
                ST_FETCH_WAIT: state_nxt = moc ? ST_DECODE :
                                           (expired ? ST_TRAP_BUS : ST_FETCH_WAIT);
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE:                  state_nxt = ST_RTYPE;
                        OP_ADDI, OP_ADDIU:         state_nxt = ST_ADDI;
                        OP_SLTI, OP_SLTIU:         state_nxt = ST_SLTI;
                        OP_ANDI:                   state_nxt = ST_ANDI;
                        OP_ORI:                    state_nxt = ST_ORI;
                        OP_XORI:                   state_nxt = ST_XORI;
                        OP_LUI:                    state_nxt = ST_LUI;
                        OP_BLTZ, OP_BEQ, OP_BNE,
                        OP_BLEZ, OP_BGTZ:          state_nxt = ST_BRANCH;
                        OP_J, OP_JAL:              state_nxt = ST_JUMP;
                        OP_LB, OP_LH, OP_LW,
                        OP_LBU, OP_LHU:            state_nxt = ST_LOAD_ADDR;
                        OP_SB, OP_SH, OP_SW, OP_SD: state_nxt = ST_STORE_ADDR;
                        default:                   state_nxt = ST_TRAP_ILL;
                    endcase
                end
                ST_RTYPE, ST_ADDI, ST_SLTI, ST_ANDI, ST_ORI, ST_XORI, ST_LUI,
                ST_JUMP, ST_LOAD_WB, ST_STORE_DONE, ST_BR_DONE:
                               state_nxt = ST_FETCH1;
                ST_BRANCH:     state_nxt = ST_BR_DONE;
                // Memory sub-decodes use the latched opcode; IR may already have moved.
                ST_LOAD_ADDR: begin
                    case (opcode_q)
                        OP_LW, OP_LH, OP_LHU: state_nxt = ST_LW_RD;
                        OP_LB, OP_LBU:        state_nxt = ST_LB_RD;
                        default:              state_nxt = ST_TRAP_ILL;
                    endcase
                end
                ST_STORE_ADDR: begin
                    case (opcode_q)
                        OP_SD, OP_SW, OP_SH:  state_nxt = ST_SW_WR;
                        OP_SB:                state_nxt = ST_SB_WR;
                        default:              state_nxt = ST_TRAP_ILL;
                    endcase
                end
                ST_LW_RD:      state_nxt = ST_LW_WAIT;
                ST_SW_WR:      state_nxt = ST_SW_WAIT;
                ST_LB_RD:      state_nxt = ST_LB_WAIT;
                ST_SB_WR:      state_nxt = ST_SB_WAIT;
                ST_LW_WAIT:    state_nxt = moc ? ST_LOAD_WB :
                                           (expired ? ST_TRAP_BUS : ST_LW_WAIT);
                ST_LB_WAIT:    state_nxt = moc ? ST_LOAD_WB :
                                           (expired ? ST_TRAP_BUS : ST_LB_WAIT);
                ST_SW_WAIT:    state_nxt = moc ? ST_STORE_DONE :
                                           (expired ? ST_TRAP_BUS : ST_SW_WAIT);
                ST_SB_WAIT:    state_nxt = moc ? ST_STORE_DONE :
                                           (expired ? ST_TRAP_BUS : ST_SB_WAIT);
                ST_TRAP_ILL:   state_nxt = trap_ack ? ST_FETCH0 : ST_TRAP_ILL;
                ST_TRAP_BUS:   state_nxt = trap_ack ? ST_FETCH0 : ST_TRAP_BUS;
                default:       state_nxt = ST_FETCH0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '0;
            opcode_q <= '0;
        end else begin
            state_q <= STATE_W'(state_nxt);
            if (legal && (cur_st == ST_DECODE)) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state        = state_q;
        mem_wait     = in_wait;
        trap_illegal = (state_q == STATE_W'(ST_TRAP_ILL));
        trap_buserr  = (state_q == STATE_W'(ST_TRAP_BUS));
    end

endmodule
